// File: rtl/bist_scan_sequencer.sv
// -----------------------------------------------------------------------------
// bist_scan_sequencer
//
// Sequencing controller for a scan-based BIST datapath. Each run is
// INIT (LFSR seed load + MISR clear), N_PATTERNS rounds of CHAIN_LEN shift
// cycles followed by one capture cycle, a CHAIN_LEN-cycle scan-out flush, and
// then DONE, where the comparator is told to sample the signature.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active low
//   START        level request; a run starts on its registered rising edge
//   ABORT        (only with BIST_ABORT_EN) cancel an active run, back to IDLE
//   SCAN_EN      1 = shift, 0 = functional/capture
//   SEED         one-cycle LFSR seed-load strobe (INIT)
//   MISR_CLR     one-cycle MISR clear strobe (INIT)
//   FINISH       one-cycle strobe in the first DONE cycle
//   BIST_END     level, high while in DONE
//   RUNNING      level, high in INIT, SHIFT, CAPTURE and FLUSH
//   PATTERN_IDX  captures completed in the current run
//
// Configuration macro: BIST_ABORT_EN adds the ABORT input.
// -----------------------------------------------------------------------------
module bist_scan_sequencer #(
   parameter int CHAIN_LEN  = 8,
   parameter int N_PATTERNS = 1000,
   parameter int CNT_W      = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
`ifdef BIST_ABORT_EN
   input  logic             ABORT,
`endif
   output logic             SCAN_EN,
   output logic             SEED,
   output logic             MISR_CLR,
   output logic             FINISH,
   output logic             BIST_END,
   output logic             RUNNING,
   output logic [CNT_W-1:0] PATTERN_IDX
);

   localparam int SC_W = $clog2(CHAIN_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SHIFT,
      S_CAPTURE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            start_q;
   logic            armed;
   logic            start_rise;
   logic            abort_hit;
   logic            last_shift;
   logic            last_pattern;
   logic [SC_W-1:0] shift_cnt;

   always_comb begin
      // start_q is forced low by reset, so the first edge after reset release
      // only samples START; a level already high then is not a rising edge.
      start_rise   = START & ~start_q & armed;
`ifdef BIST_ABORT_EN
      abort_hit    = ABORT & (state inside {S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH});
`else
      abort_hit    = 1'b0;
`endif
      last_shift   = (shift_cnt == SC_W'(CHAIN_LEN - 1));
      last_pattern = ((PATTERN_IDX + CNT_W'(1)) == CNT_W'(N_PATTERNS));

      state_nxt = state;
      case (state)
         S_IDLE:    if (start_rise) state_nxt = S_INIT;
         S_INIT:    state_nxt = S_SHIFT;
         S_SHIFT:   if (last_shift) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = last_pattern ? S_FLUSH : S_SHIFT;
         S_FLUSH:   if (last_shift) state_nxt = S_DONE;
         S_DONE:    if (!START) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_IDLE;
   end

   // Outputs are registered from the next state, so each one is valid in the
   // same cycle as the state it belongs to and never glitches.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= S_IDLE;
         start_q     <= 1'b0;
         armed       <= 1'b0;
         shift_cnt   <= '0;
         PATTERN_IDX <= '0;
         SCAN_EN     <= 1'b0;
         SEED        <= 1'b0;
         MISR_CLR    <= 1'b0;
         FINISH      <= 1'b0;
         BIST_END    <= 1'b0;
         RUNNING     <= 1'b0;
      end else begin
         state    <= state_nxt;
         start_q  <= START;
         armed    <= 1'b1;
         SCAN_EN  <= (state_nxt == S_SHIFT) || (state_nxt == S_FLUSH);
         SEED     <= (state_nxt == S_INIT);
         MISR_CLR <= (state_nxt == S_INIT);
         FINISH   <= (state_nxt == S_DONE) && (state != S_DONE);
         BIST_END <= (state_nxt == S_DONE);
         RUNNING  <= state_nxt inside {S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH};

         if ((state_nxt == state) && ((state == S_SHIFT) || (state == S_FLUSH)))
            shift_cnt <= shift_cnt + SC_W'(1);
         else
            shift_cnt <= '0;

         if (state_nxt == S_INIT)
            PATTERN_IDX <= '0;
         else if ((state == S_CAPTURE) && !abort_hit &&
                  (PATTERN_IDX != CNT_W'(N_PATTERNS)))
            PATTERN_IDX <= PATTERN_IDX + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bist_scan_sequencer
//
// Two sequencer instances: A (CHAIN_LEN=4, N_PATTERNS=3) and B (CHAIN_LEN=1,
// N_PATTERNS=1). Both are compared every cycle against a reference model that
// derives the outputs from the run-relative cycle number, plus a hand-written
// vector table for the nominal run and directed checks for the corner cases.
// Defining BIST_ABORT_EN also exercises the ABORT input.
// -----------------------------------------------------------------------------
module tb_bist_scan_sequencer;

   logic       CLK = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       abort_a = 1'b0, abort_b = 1'b0;
   logic       a_scan_en, a_seed, a_misr_clr, a_finish, a_bist_end, a_running;
   logic [3:0] a_idx;
   logic       b_scan_en, b_seed, b_misr_clr, b_finish, b_bist_end, b_running;
   logic [1:0] b_idx;

   always #5 CLK = ~CLK;

   bist_scan_sequencer #(.CHAIN_LEN(4), .N_PATTERNS(3), .CNT_W(4)) dut_a (
      .CLK(CLK), .RST(rst_a), .START(start_a),
`ifdef BIST_ABORT_EN
      .ABORT(abort_a),
`endif
      .SCAN_EN(a_scan_en), .SEED(a_seed), .MISR_CLR(a_misr_clr),
      .FINISH(a_finish), .BIST_END(a_bist_end), .RUNNING(a_running),
      .PATTERN_IDX(a_idx)
   );

   bist_scan_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1), .CNT_W(2)) dut_b (
      .CLK(CLK), .RST(rst_b), .START(start_b),
`ifdef BIST_ABORT_EN
      .ABORT(abort_b),
`endif
      .SCAN_EN(b_scan_en), .SEED(b_seed), .MISR_CLR(b_misr_clr),
      .FINISH(b_finish), .BIST_END(b_bist_end), .RUNNING(b_running),
      .PATTERN_IDX(b_idx)
   );

   typedef struct {
      bit          scan_en, seed, misr_clr, finish, bist_end, running;
      int unsigned idx;
   } out_t;

   typedef struct {
      int unsigned k;
      bit          start;
      bit          scan_en, seed, finish, bist_end, running;
      int unsigned idx;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   int fin_cnt_a = 0;

   // reference model: 0 = idle, 1 = running (cycle m_k of the run), 2 = done
   int unsigned cl [2] = '{4, 1};
   int unsigned np [2] = '{3, 1};
   int unsigned m_mode [2] = '{0, 0};
   int unsigned m_k [2] = '{0, 0};
   int unsigned m_hold [2] = '{0, 0};
   bit          m_sq [2] = '{0, 0};
   bit          m_armed [2] = '{0, 0};

   function automatic int unsigned done_cyc(int s);
      return 2 + np[s] * (cl[s] + 1) + cl[s];
   endfunction

   function automatic out_t model_out(int s);
      out_t o;
      int unsigned len, r;
      len = cl[s] + 1;
      o.scan_en = 0; o.seed = 0; o.misr_clr = 0; o.finish = 0;
      o.bist_end = 0; o.running = 0; o.idx = m_hold[s];
      if (m_mode[s] == 1) begin
         o.running = 1;
         if (m_k[s] == 1) begin
            o.seed = 1; o.misr_clr = 1; o.idx = 0;
         end else if (m_k[s] < 2 + np[s] * len) begin
            r = m_k[s] - 2;
            o.idx = r / len;
            o.scan_en = (r % len) < cl[s];
         end else begin
            o.scan_en = 1; o.idx = np[s];
         end
      end else if (m_mode[s] == 2) begin
         o.bist_end = 1;
         o.finish = (m_k[s] == done_cyc(s));
         o.idx = np[s];
      end
      return o;
   endfunction

   task automatic model_reset(int s);
      m_mode[s] = 0; m_hold[s] = 0; m_sq[s] = 0; m_armed[s] = 0;
   endtask

   task automatic model_edge(int s, bit rst, bit start, bit abort);
      out_t cur;
      if (!rst) begin
         model_reset(s);
         return;
      end
      cur = model_out(s);
      case (m_mode[s])
         0: if (m_armed[s] && start && !m_sq[s]) begin
               m_mode[s] = 1; m_k[s] = 1;
            end
         1: if (abort) begin
               m_hold[s] = cur.idx; m_mode[s] = 0;
            end else begin
               m_k[s]++;
               if (m_k[s] == done_cyc(s)) m_mode[s] = 2;
            end
         default: if (!start) begin
               m_mode[s] = 0; m_hold[s] = np[s];
            end else m_k[s]++;
      endcase
      m_sq[s] = start;
      m_armed[s] = 1;
   endtask

   function automatic out_t dut_out(int s);
      out_t o;
      if (s == 0) begin
         o.scan_en = a_scan_en; o.seed = a_seed; o.misr_clr = a_misr_clr;
         o.finish = a_finish; o.bist_end = a_bist_end; o.running = a_running;
         o.idx = a_idx;
      end else begin
         o.scan_en = b_scan_en; o.seed = b_seed; o.misr_clr = b_misr_clr;
         o.finish = b_finish; o.bist_end = b_bist_end; o.running = b_running;
         o.idx = b_idx;
      end
      return o;
   endfunction

   task automatic check(string name, int s, out_t e);
      out_t g;
      g = dut_out(s);
      n_checks++;
      if (g != e) begin
         n_errors++;
         $display("FAIL %s dut%0d t=%0t got se=%b sd=%b mc=%b fin=%b end=%b run=%b idx=%0d expected se=%b sd=%b mc=%b fin=%b end=%b run=%b idx=%0d",
                  name, s, $time, g.scan_en, g.seed, g.misr_clr, g.finish, g.bist_end,
                  g.running, g.idx, e.scan_en, e.seed, e.misr_clr, e.finish,
                  e.bist_end, e.running, e.idx);
      end
   endtask

   task automatic check_val(string name, int unsigned got, int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // One clock: models advance on the rising edge, DUTs checked on the falling edge.
   task automatic tick();
      @(posedge CLK);
      model_edge(0, rst_a, start_a, abort_a);
      model_edge(1, rst_b, start_b, abort_b);
      @(negedge CLK);
      check("model", 0, model_out(0));
      check("model", 1, model_out(1));
      if (a_finish) fin_cnt_a++;
   endtask

   task automatic async_reset(int s);
      if (s == 0) rst_a = 1'b0; else rst_b = 1'b0;
      #1;
      model_reset(s);
      check("async_rst", s, model_out(s));
   endtask

   vec_t vec [12];

   initial begin
      out_t e;
      int unsigned ti;
      int fin_before;
      bit rel [2];

      vec[0]  = '{1,  1, 0, 1, 0, 0, 1, 0};
      vec[1]  = '{2,  1, 1, 0, 0, 0, 1, 0};
      vec[2]  = '{5,  1, 1, 0, 0, 0, 1, 0};
      vec[3]  = '{6,  1, 0, 0, 0, 0, 1, 0};
      vec[4]  = '{7,  1, 1, 0, 0, 0, 1, 1};
      vec[5]  = '{11, 1, 0, 0, 0, 0, 1, 1};
      vec[6]  = '{12, 1, 1, 0, 0, 0, 1, 2};
      vec[7]  = '{16, 1, 0, 0, 0, 0, 1, 2};
      vec[8]  = '{17, 1, 1, 0, 0, 0, 1, 3};
      vec[9]  = '{20, 1, 1, 0, 0, 0, 1, 3};
      vec[10] = '{21, 1, 0, 0, 1, 1, 0, 3};
      vec[11] = '{22, 1, 0, 0, 0, 1, 0, 3};

      // reset held with START high, then released with START still high
      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b1; start_b = 1'b1;
      @(negedge CLK);
      repeat (3) tick();
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (5) tick();
      check_val("no_run_after_reset", a_running, 0);
      start_a = 1'b0; start_b = 1'b0;
      tick();

      // nominal run on A against the hand-written table
      start_a = 1'b1;
      ti = 0;
      fin_cnt_a = 0;
      for (int unsigned k = 1; k <= 22; k++) begin
         tick();
         if (ti < 12 && vec[ti].k == k) begin
            e.scan_en = vec[ti].scan_en; e.seed = vec[ti].seed;
            e.misr_clr = vec[ti].seed; e.finish = vec[ti].finish;
            e.bist_end = vec[ti].bist_end; e.running = vec[ti].running;
            e.idx = vec[ti].idx;
            check($sformatf("table_k%0d", k), 0, e);
            start_a = vec[ti].start;
            ti++;
         end
      end

      // DONE hold with START high, then drop START
      repeat (50) tick();
      check_val("done_hold_end", a_bist_end, 1);
      check_val("finish_once", fin_cnt_a, 1);
      start_a = 1'b0;
      tick();
      check_val("end_drop", a_bist_end, 0);

      // reset in cycle 9, then a full run from PATTERN_IDX=0
      start_a = 1'b1;
      fin_before = fin_cnt_a;
      for (int k = 1; k <= 9; k++) tick();
      async_reset(0);
      tick();
      check_val("no_finish_after_abort_rst", fin_cnt_a, fin_before);
      start_a = 1'b0; rst_a = 1'b1;
      tick();
      start_a = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 1) check_val("rerun_idx0", a_idx, 0);
         if (k == 21) check_val("rerun_finish", a_finish, 1);
      end
      start_a = 1'b0;
      tick();

      // CHAIN_LEN=1, N_PATTERNS=1 with a second START pulse mid-run
      start_b = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         case (k)
            1: check_val("b_seed_c1", b_seed, 1);
            2: begin check_val("b_shift_c2", b_scan_en, 1); start_b = 1'b0; end
            3: begin check_val("b_capture_c3", b_scan_en, 0); start_b = 1'b1; end
            4: check_val("b_flush_c4", {b_scan_en, b_idx}, 3'b101);
            5: check_val("b_finish_c5", {b_finish, b_bist_end}, 2'b11);
            6: check_val("b_finish_once", {b_finish, b_bist_end}, 2'b01);
            default: ;
         endcase
      end
      start_b = 1'b0;
      tick();

`ifdef BIST_ABORT_EN
      // abort in cycle 13 of the nominal run
      start_a = 1'b1;
      fin_before = fin_cnt_a;
      for (int k = 1; k <= 13; k++) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check_val("abort_idx", a_idx, 2);
      check_val("abort_outs", {a_scan_en, a_running, a_bist_end}, 0);
      repeat (25) tick();
      check_val("abort_no_finish", fin_cnt_a, fin_before);
      start_a = 1'b0;
      tick();
`endif

      // randomized stimulus on both instances against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) start_a = ~start_a;
         if ($urandom_range(0, 7) == 0) start_b = ~start_b;
`ifdef BIST_ABORT_EN
         abort_a = ($urandom_range(0, 59) == 0);
         abort_b = ($urandom_range(0, 59) == 0);
`endif
         rel[0] = 0; rel[1] = 0;
         if ($urandom_range(0, 499) == 0) begin async_reset(0); rel[0] = 1; end
         if ($urandom_range(0, 499) == 0) begin async_reset(1); rel[1] = 1; end
         tick();
         if (rel[0]) rst_a = 1'b1;
         if (rel[1]) rst_b = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
